// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode and controller state types for the sequential ALU
package alu_pkg;

    typedef enum logic [2:0] {
        OP_NEG_A = 3'b000,
        OP_NEG_B = 3'b001,
        OP_ADD   = 3'b010,
        OP_SUB   = 3'b011,
        OP_AND   = 3'b100,
        OP_OR    = 3'b101,
        OP_MUL   = 3'b110,
        OP_XOR   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/shift_add_mul.sv
// rtl/shift_add_mul.sv - LSB-first shift-add unsigned multiplier, one bit per cycle
module shift_add_mul #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [CW-1:0]      cnt_q;
    logic               busy_q;

    // Load operands on start, then add the shifted multiplicand for each set multiplier bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else if (start) begin
            mcand_q  <= {{WIDTH{1'b0}}, multiplicand};
            mplier_q <= multiplier;
            acc_q    <= '0;
            cnt_q    <= CW'(WIDTH - 1);
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            if (mplier_q[0]) begin
                acc_q <= acc_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            if (cnt_q == '0) begin
                busy_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    // done marks the cycle whose closing edge consumes the last multiplier bit
    assign busy    = busy_q;
    assign done    = busy_q && (cnt_q == '0);
    assign product = acc_q;

endmodule

// File: rtl/seq_alu_mul.sv
// rtl/seq_alu_mul.sv - registered WIDTH-bit ALU with multi-cycle multiply and valid/ready handshake
module seq_alu_mul
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 flag_z,
    output logic                 flag_n,
    output logic                 flag_c,
    output logic                 flag_v
);

    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_e             state_q;
    logic               out_valid_q;
    logic [2*WIDTH-1:0] result_q;
    logic               z_q, n_q, c_q, v_q;

    logic               accept;
    logic               is_mul;
    logic               mul_busy;
    logic               mul_done;
    logic [2*WIDTH-1:0] product;

    logic               add_c;
    logic [WIDTH-1:0]   add_lo, sub_lo, neg_a, neg_b;
    logic [WIDTH-1:0]   alu_lo_d;
    logic               alu_c_d, alu_v_d;

    // New ops only enter when idle and the previous result is gone or leaving this edge
    assign in_ready = (state_q == IDLE) && !mul_busy && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign is_mul   = (op_e'(op) == OP_MUL);

    assign {add_c, add_lo} = {1'b0, a} + {1'b0, b};
    assign sub_lo          = a + ~b + ONE;
    assign neg_a           = ~a + ONE;
    assign neg_b           = ~b + ONE;

    // Single-cycle ops: low-half result plus carry/borrow and signed overflow
    always_comb begin
        alu_lo_d = '0;
        alu_c_d  = 1'b0;
        alu_v_d  = 1'b0;
        case (op_e'(op))
            OP_NEG_A: begin
                alu_lo_d = neg_a;
                alu_v_d  = (a == MIN_NEG);
            end
            OP_NEG_B: begin
                alu_lo_d = neg_b;
                alu_v_d  = (b == MIN_NEG);
            end
            OP_ADD: begin
                alu_lo_d = add_lo;
                alu_c_d  = add_c;
                alu_v_d  = (a[WIDTH-1] == b[WIDTH-1]) && (add_lo[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_lo_d = sub_lo;
                alu_c_d  = (a < b);
                alu_v_d  = (a[WIDTH-1] != b[WIDTH-1]) && (sub_lo[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  alu_lo_d = a & b;
            OP_OR:   alu_lo_d = a | b;
            OP_XOR:  alu_lo_d = a ^ b;
            default: alu_lo_d = '0;
        endcase
    end

    shift_add_mul #(.WIDTH(WIDTH)) u_mul (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (accept && is_mul),
        .multiplicand (a),
        .multiplier   (b),
        .busy         (mul_busy),
        .done         (mul_done),
        .product      (product)
    );

    // Controller: single-cycle ops complete from IDLE, MUL waits on the multiplier then publishes in DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            z_q         <= 1'b0;
            n_q         <= 1'b0;
            c_q         <= 1'b0;
            v_q         <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept && is_mul) begin
                        state_q     <= MUL;
                        out_valid_q <= 1'b0;
                    end else if (accept) begin
                        out_valid_q <= 1'b1;
                        result_q    <= {{WIDTH{1'b0}}, alu_lo_d};
                        z_q         <= (alu_lo_d == '0);
                        n_q         <= alu_lo_d[WIDTH-1];
                        c_q         <= alu_c_d;
                        v_q         <= alu_v_d;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                end
                MUL: begin
                    if (mul_done) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b1;
                    result_q    <= product;
                    z_q         <= (product == '0);
                    n_q         <= product[2*WIDTH-1];
                    c_q         <= 1'b0;
                    v_q         <= |product[2*WIDTH-1:WIDTH];
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flag_z    = z_q;
    assign flag_n    = n_q;
    assign flag_c    = c_q;
    assign flag_v    = v_q;

endmodule

// File: tb/tb_seq_alu_mul.sv
// tb/tb_seq_alu_mul.sv - self-checking bench for seq_alu_mul at WIDTH 4 and 8
module tb_seq_alu_mul;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic [3:0] zncv;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       out_ready;
    logic       sel;
    logic [2:0] op;
    logic [7:0] a, b;

    logic       iv4, in_ready4, out_valid4, z4, n4, c4, v4;
    logic [7:0] result4;
    logic       iv8, in_ready8, out_valid8, z8, n8, c8, v8;
    logic [15:0] result8;

    logic        cur_in_ready, cur_ov;
    logic [15:0] cur_res;
    logic [3:0]  cur_flags;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign iv4 = in_valid & ~sel;
    assign iv8 = in_valid & sel;
    assign cur_in_ready = sel ? in_ready8 : in_ready4;
    assign cur_ov       = sel ? out_valid8 : out_valid4;
    assign cur_res      = sel ? result8 : {8'h00, result4};
    assign cur_flags    = sel ? {z8, n8, c8, v8} : {z4, n4, c4, v4};

    seq_alu_mul #(.WIDTH(4)) d4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(in_ready4), .op(op),
        .a(a[3:0]), .b(b[3:0]), .out_valid(out_valid4), .out_ready(out_ready),
        .result(result4), .flag_z(z4), .flag_n(n4), .flag_c(c4), .flag_v(v4)
    );

    seq_alu_mul #(.WIDTH(8)) d8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(in_ready8), .op(op),
        .a(a), .b(b), .out_valid(out_valid8), .out_ready(out_ready),
        .result(result8), .flag_z(z8), .flag_n(n8), .flag_c(c8), .flag_v(v8)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic modulo 2^w; returns {z,n,c,v,result[15:0]}
    function automatic logic [19:0] model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y, input int w);
        int m, ua, ub, sa, sb, r, s;
        bit c, v, z, n;
        m  = 1 << w;
        ua = int'(x) % m;
        ub = int'(y) % m;
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        c = 1'b0; v = 1'b0; r = 0;
        case (o)
            3'd0: begin r = (m - ua) % m; v = (ua == m / 2); end
            3'd1: begin r = (m - ub) % m; v = (ub == m / 2); end
            3'd2: begin r = (ua + ub) % m; c = (ua + ub) >= m; s = sa + sb; v = (s >= m / 2) || (s < -(m / 2)); end
            3'd3: begin r = (ua - ub + m) % m; c = ua < ub; s = sa - sb; v = (s >= m / 2) || (s < -(m / 2)); end
            3'd4: r = ua & ub;
            3'd5: r = ua | ub;
            3'd6: begin r = ua * ub; v = (r >= m); end
            default: r = ua ^ ub;
        endcase
        z = (r == 0);
        n = (o == 3'd6) ? (r >= m * m / 2) : (r >= m / 2);
        return {z, n, c, v, 16'(r)};
    endfunction

    // One transaction on the selected DUT; starts and ends on a falling edge
    task automatic run_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y, input bit bp,
                          output logic [15:0] r, output logic [3:0] f);
        int n;
        op = o; a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
        r = '0; f = '0;
        n = 0;
        while (!cur_in_ready && n < 20) begin
            @(posedge clk); @(negedge clk); n++;
        end
        if (n >= 20) begin
            total++; bad++;
            $display("FAIL accept_timeout actual=%0d required<20", n);
        end
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (n < 40) begin
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (cur_ov && out_ready) begin
                r = cur_res; f = cur_flags;
                break;
            end
            @(posedge clk); @(negedge clk); n++;
        end
        if (n >= 40) begin
            total++; bad++;
            $display("FAIL result_timeout actual=%0d required<40", n);
        end else begin
            @(posedge clk); @(negedge clk);
        end
        out_ready = 1'b1;
    endtask

    vec_t        tv[12];
    logic [15:0] r;
    logic [3:0]  f;
    logic [19:0] m;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; sel = 1'b0;
        op = '0; a = '0; b = '0;

        tv[0]  = '{3'd2, 8'h7, 8'h9, 8'h00, 4'b1010};
        tv[1]  = '{3'd3, 8'h3, 8'h5, 8'h0E, 4'b0110};
        tv[2]  = '{3'd3, 8'h8, 8'h1, 8'h07, 4'b0001};
        tv[3]  = '{3'd0, 8'h8, 8'h0, 8'h08, 4'b0101};
        tv[4]  = '{3'd1, 8'h0, 8'h1, 8'h0F, 4'b0100};
        tv[5]  = '{3'd6, 8'hF, 8'hF, 8'hE1, 4'b0101};
        tv[6]  = '{3'd6, 8'h0, 8'h7, 8'h00, 4'b1000};
        tv[7]  = '{3'd4, 8'hC, 8'hA, 8'h08, 4'b0100};
        tv[8]  = '{3'd5, 8'hC, 8'hA, 8'h0E, 4'b0100};
        tv[9]  = '{3'd7, 8'hC, 8'hA, 8'h06, 4'b0000};
        tv[10] = '{3'd2, 8'h1, 8'h1, 8'h02, 4'b0000};
        tv[11] = '{3'd0, 8'h0, 8'h0, 8'h00, 4'b1000};

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_ov4", out_valid4, 0);
        chk("rst_ov8", out_valid8, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_rdy4", in_ready4, 1);
        chk("rst_rdy8", in_ready8, 1);
        chk("rst_res4", result4, 0);
        chk("rst_res8", result8, 0);
        chk("rst_flg4", {z4, n4, c4, v4}, 0);

        // directed table, WIDTH=4
        for (int i = 0; i < 12; i++) begin
            run_op(tv[i].op, tv[i].a, tv[i].b, 1'b0, r, f);
            chk($sformatf("tab%0d_res", i), r, {8'h00, tv[i].res});
            chk($sformatf("tab%0d_flg", i), f, tv[i].zncv);
        end

        // MUL 15*15 latency, ignored in_valid while busy, held output under backpressure
        op = 3'd6; a = 8'hF; b = 8'hF; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) begin op = 3'd2; a = 8'h1; b = 8'h1; end
            chk($sformatf("mul_busy_rdy%0d", i), in_ready4, 0);
            chk($sformatf("mul_busy_ov%0d", i), out_valid4, 0);
        end
        @(negedge clk);
        chk("mul_ov", out_valid4, 1);
        chk("mul_res", result4, 8'hE1);
        chk("mul_flg", {z4, n4, c4, v4}, 4'b0101);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("hold_res%0d", i), result4, 8'hE1);
            chk($sformatf("hold_rdy%0d", i), in_ready4, 0);
            chk($sformatf("hold_ov%0d", i), out_valid4, 1);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("rel_ov", out_valid4, 0);
        chk("rel_rdy", in_ready4, 1);

        // back-to-back logic ops, one per cycle
        op = 3'd4; a = 8'hC; b = 8'hA; in_valid = 1'b1;
        @(negedge clk);
        chk("b2b_and", result4, 8'h08);
        chk("b2b_and_ov", out_valid4, 1);
        op = 3'd5;
        @(negedge clk);
        chk("b2b_or", result4, 8'h0E);
        op = 3'd7;
        @(negedge clk);
        chk("b2b_xor", result4, 8'h06);
        chk("b2b_xor_ov", out_valid4, 1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_end_ov", out_valid4, 0);

        // reset two cycles into a multiply
        op = 3'd6; a = 8'h3; b = 8'h5; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst_ov", out_valid4, 0);
        chk("mrst_res", result4, 0);
        chk("mrst_flg", {z4, n4, c4, v4}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("mrst_rdy", in_ready4, 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("mrst_quiet%0d", i), out_valid4, 0);
        end
        run_op(3'd2, 8'h1, 8'h1, 1'b0, r, f);
        chk("mrst_add_res", r, 16'h0002);
        chk("mrst_add_flg", f, 4'b0000);

        // random regression against the model, both widths, random backpressure
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            @(negedge clk);
            for (int k = 0; k < 200; k++) begin
                logic [2:0] ro;
                logic [7:0] ra, rb;
                ro = 3'($urandom_range(0, 7));
                ra = 8'($urandom);
                rb = 8'($urandom);
                m  = model(ro, ra, rb, (s == 0) ? 4 : 8);
                run_op(ro, ra, rb, 1'b1, r, f);
                chk($sformatf("rnd_w%0d_%0d_res op=%0d a=%0h b=%0h", (s == 0) ? 4 : 8, k, ro, ra, rb), r, m[15:0]);
                chk($sformatf("rnd_w%0d_%0d_flg op=%0d a=%0h b=%0h", (s == 0) ? 4 : 8, k, ro, ra, rb), f, m[19:16]);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
